short_preamble_detector: RTL and testbench

- Streaming 802.11-style short-preamble detector using delayed autocorrelation with a 16-sample lag.
- Sits directly upstream of the long-preamble search stage and passes every sample through unmodified.
- Asserts o_tlast on the single output sample at which a short-preamble plateau is confirmed. The downstream stage uses that tlast as its search start.

---
 rtl/short_preamble_detector.sv | 204 ++++++++++++++++++++
 tb/tb_short_preamble_detector.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/short_preamble_detector.sv
`default_nettype none
// =============================================================================
// Module   : short_preamble_detector
// Brief    : 16-lag delayed-autocorrelation plateau detector; passes samples
//            through unchanged and tags the plateau-confirming sample with tlast.
// Revision : 1.0 - initial release
// =============================================================================
module short_preamble_detector #(
    parameter int WIDTH       = 32,
    parameter int LAG         = 16,
    parameter int WINDOW      = 32,
    parameter int PLATEAU_LEN = 64,
    parameter int HOLDOFF     = 320,
    parameter int MIN_POWER   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       thresh,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [31:0]      detect_count
);
    localparam int c_HW    = WIDTH / 2;
    localparam int c_MW    = WIDTH + 1;
    localparam int c_PW    = 18;
    localparam int c_SHIFT = 15;
    localparam int c_WB    = $clog2(WINDOW);
    localparam int c_SW    = c_PW + c_WB;
    localparam int c_RW    = $clog2(PLATEAU_LEN + 1);
    localparam int c_HDW   = $clog2(HOLDOFF + 1);
    localparam logic [c_SW-1:0]  c_MINP     = c_SW'(MIN_POWER);
    localparam logic [c_RW-1:0]  c_RUN_LAST = c_RW'(PLATEAU_LEN - 1);
    localparam logic [c_HDW-1:0] c_HOLD     = c_HDW'(HOLDOFF);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_PLATEAU = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    logic                   w_en;
    logic                   w_unused_tlast;
    logic [WIDTH-1:0]       r_dly [LAG];
    logic signed [c_MW-1:0] w_ai, w_aq, w_ci, w_cq, w_pre, w_pim, w_pe;
    logic                   r_v1, r_v2, r_v3, r_v4, r_tl4;
    logic [WIDTH-1:0]       r_d1, r_d2, r_d3, r_d4;
    logic signed [c_PW-1:0] r_p_re, r_p_im;
    logic [c_PW-1:0]        r_e;
    logic signed [c_PW-1:0] r_hre [WINDOW];
    logic signed [c_PW-1:0] r_him [WINDOW];
    logic [c_PW-1:0]        r_he  [WINDOW];
    logic [c_WB-1:0]        r_wptr;
    logic signed [c_SW-1:0] r_cre, r_cim;
    logic [c_SW-1:0]        r_psum;
    logic [c_SW-1:0]        w_abs_re, w_abs_im, w_mx, w_mn;
    logic [c_SW:0]          w_mag;
    logic [c_SW+3:0]        w_pth;
    logic                   w_above, r_above;
    state_t                 r_state, w_state_nxt;
    logic [c_RW-1:0]        r_run, w_run_nxt;
    logic [c_HDW-1:0]       r_hold, w_hold_nxt;
    logic                   w_tag;
    logic [31:0]            r_det;

    assign w_unused_tlast = i_tlast;
    assign w_en     = ~r_v4 | o_tready;
    assign i_tready = w_en;

    // x[n] * conj(x[n-LAG]) and |x[n-LAG]|^2 at full precision
    assign w_ai  = c_MW'($signed(i_tdata[WIDTH-1:c_HW]));
    assign w_aq  = c_MW'($signed(i_tdata[c_HW-1:0]));
    assign w_ci  = c_MW'($signed(r_dly[LAG-1][WIDTH-1:c_HW]));
    assign w_cq  = c_MW'($signed(r_dly[LAG-1][c_HW-1:0]));
    assign w_pre = w_ai * w_ci + w_aq * w_cq;
    assign w_pim = w_aq * w_ci - w_ai * w_cq;
    assign w_pe  = w_ci * w_ci + w_cq * w_cq;

    assign w_abs_re = r_cre[c_SW-1] ? -r_cre : r_cre;
    assign w_abs_im = r_cim[c_SW-1] ? -r_cim : r_cim;
    assign w_mx     = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
    assign w_mn     = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
    assign w_mag    = (c_SW+1)'(w_mx) + (c_SW+1)'(w_mn >> 2);
    assign w_pth    = (c_SW+4)'(r_psum) * (c_SW+4)'(thresh);
    assign w_above  = (r_psum >= c_MINP) && ({3'b000, w_mag} >= (w_pth >> 4));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAG; k++) r_dly[k] <= '0;
            for (int k = 0; k < WINDOW; k++) begin
                r_hre[k] <= '0;
                r_him[k] <= '0;
                r_he[k]  <= '0;
            end
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_d1 <= '0;   r_d2 <= '0;   r_d3 <= '0;
            r_p_re <= '0; r_p_im <= '0; r_e <= '0;
            r_wptr <= '0; r_cre <= '0;  r_cim <= '0; r_psum <= '0;
            r_above <= 1'b0;
        end else if (w_en) begin
            if (i_tvalid) begin
                r_dly[0] <= i_tdata;
                for (int k = 1; k < LAG; k++) r_dly[k] <= r_dly[k-1];
            end
            r_v1   <= i_tvalid;
            r_d1   <= i_tdata;
            r_p_re <= c_PW'(w_pre >>> c_SHIFT);
            r_p_im <= c_PW'(w_pim >>> c_SHIFT);
            r_e    <= c_PW'(w_pe >>> c_SHIFT);
            // Recursive window sums: add newest, retire the entry WINDOW samples old
            if (r_v1) begin
                r_cre  <= r_cre + c_SW'(r_p_re) - c_SW'(r_hre[r_wptr]);
                r_cim  <= r_cim + c_SW'(r_p_im) - c_SW'(r_him[r_wptr]);
                r_psum <= r_psum + c_SW'(r_e) - c_SW'(r_he[r_wptr]);
                r_hre[r_wptr] <= r_p_re;
                r_him[r_wptr] <= r_p_im;
                r_he[r_wptr]  <= r_e;
                r_wptr <= r_wptr + c_WB'(1);
            end
            r_v2    <= r_v1;
            r_d2    <= r_d1;
            r_v3    <= r_v2;
            r_d3    <= r_d2;
            r_above <= w_above;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_hold_nxt  = r_hold;
        w_tag       = 1'b0;
        case (r_state)
            S_SEARCH: begin
                if (r_above) begin
                    w_run_nxt   = c_RW'(1);
                    w_state_nxt = S_PLATEAU;
                end else begin
                    w_run_nxt = '0;
                end
            end
            S_PLATEAU: begin
                if (!r_above) begin
                    w_run_nxt   = '0;
                    w_state_nxt = S_SEARCH;
                end else if (r_run == c_RUN_LAST) begin
                    w_tag       = 1'b1;
                    w_run_nxt   = '0;
                    w_hold_nxt  = c_HOLD;
                    w_state_nxt = S_HOLDOFF;
                end else begin
                    w_run_nxt = r_run + c_RW'(1);
                end
            end
            S_HOLDOFF: begin
                if (r_hold <= c_HDW'(1)) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = S_SEARCH;
                end else begin
                    w_hold_nxt = r_hold - c_HDW'(1);
                end
            end
            default: begin
                w_run_nxt   = '0;
                w_hold_nxt  = '0;
                w_state_nxt = S_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_SEARCH;
            r_run   <= '0;
            r_hold  <= '0;
            r_det   <= '0;
            r_v4    <= 1'b0;
            r_tl4   <= 1'b0;
            r_d4    <= '0;
        end else if (w_en) begin
            r_v4  <= r_v3;
            r_d4  <= r_d3;
            r_tl4 <= r_v3 & w_tag;
            if (r_v3) begin
                r_state <= w_state_nxt;
                r_run   <= w_run_nxt;
                r_hold  <= w_hold_nxt;
                if (w_tag && (r_det != 32'hFFFF_FFFF)) r_det <= r_det + 32'd1;
            end
        end
    end

    assign o_tdata      = r_d4;
    assign o_tlast      = r_tl4;
    assign o_tvalid     = r_v4;
    assign detect_count = r_det;

endmodule
`default_nettype wire

// File: tb/tb_short_preamble_detector.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_short_preamble_detector
// Brief    : scoreboard bench; expected beats come from a windowed-sum reference.
// Revision : 1.0 - initial release
// =============================================================================
module tb_short_preamble_detector;
    localparam int N_MAX = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  thresh = 4'd12;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [31:0] detect_count;

    short_preamble_detector dut (
        .clk(clk), .reset(reset), .thresh(thresh),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .detect_count(detect_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; bit tl; int idx; } exp_t;
    exp_t   exp_q[$];
    exp_t   m_exp;
    int     tl_idx[$];
    int     errors = 0;
    int     checks = 0;
    int     stim_i [N_MAX];
    int     stim_q [N_MAX];
    bit     exp_tl [N_MAX];
    longint m_pr [N_MAX];
    longint m_pi [N_MAX];
    longint m_pe [N_MAX];
    int     exp_det;
    int     vld_pct = 100;
    int     rdy_pct = 100;
    logic [15:0] pat_i, pat_q;
    bit     first_acc_seen = 1'b0;
    bit     first_out_seen = 1'b0;
    longint t_first_drive = 0;
    longint t_first_out = 0;
    int     s2_idx;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] pack(input int idx);
        int a, b;
        a = stim_i[idx];
        b = stim_q[idx];
        return {a[15:0], b[15:0]};
    endfunction

    // Monitor: a beat is taken whenever valid and ready are both high
    always begin
        @(negedge clk);
        #3;
        if (!reset && o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                m_exp = exp_q.pop_front();
                check("o_tdata", o_tdata, m_exp.data);
                check("o_tlast", o_tlast, m_exp.tl);
                if (o_tlast) tl_idx.push_back(m_exp.idx);
                if (!first_out_seen) begin
                    first_out_seen = 1'b1;
                    t_first_out = $time - 3;
                end
            end
        end
    end

    // Reference: correlation/power recomputed per sample over the whole window
    task automatic run_model(input int thr, input int n);
        longint cr, ci, pw, ar, ai, mx, mn, mag;
        int run, hold;
        bit above;
        for (int k = 0; k < n; k++) begin
            longint a, b, c, d;
            a = stim_i[k];
            b = stim_q[k];
            c = (k >= 16) ? stim_i[k-16] : 0;
            d = (k >= 16) ? stim_q[k-16] : 0;
            m_pr[k] = (a * c + b * d) >>> 15;
            m_pi[k] = (b * c - a * d) >>> 15;
            m_pe[k] = (c * c + d * d) >>> 15;
        end
        run = 0;
        hold = 0;
        exp_det = 0;
        for (int k = 0; k < n; k++) begin
            cr = 0; ci = 0; pw = 0;
            for (int j = (k >= 31) ? k - 31 : 0; j <= k; j++) begin
                cr += m_pr[j];
                ci += m_pi[j];
                pw += m_pe[j];
            end
            ar = (cr < 0) ? -cr : cr;
            ai = (ci < 0) ? -ci : ci;
            mx = (ar > ai) ? ar : ai;
            mn = (ar > ai) ? ai : ar;
            mag = mx + mn / 4;
            above = (pw >= 1024) && (mag >= (pw * thr) / 16);
            exp_tl[k] = 1'b0;
            if (hold > 0) begin
                hold--;
            end else if (above) begin
                run++;
                if (run == 64) begin
                    exp_tl[k] = 1'b1;
                    exp_det++;
                    hold = 320;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic send(input int idx);
        bit acc;
        int tries;
        longint t_neg;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 500) begin
            @(negedge clk);
            t_neg = $time;
            o_tready = ($urandom_range(0, 99) < rdy_pct);
            i_tvalid = ($urandom_range(0, 99) < vld_pct);
            i_tdata  = pack(idx);
            #2;
            acc = i_tvalid && i_tready;
            @(posedge clk);
            tries++;
            if (acc) begin
                exp_q.push_back('{pack(idx), exp_tl[idx], idx});
                if (!first_acc_seen) begin
                    first_acc_seen = 1'b1;
                    t_first_drive = t_neg;
                end
            end
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        @(negedge clk);
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        first_acc_seen = 1'b0;
        first_out_seen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_detect_count", detect_count, 0);
        check("rst_i_tready", i_tready, 1);
    endtask

    task automatic clear_stim();
        for (int k = 0; k < N_MAX; k++) begin
            stim_i[k] = 0;
            stim_q[k] = 0;
        end
    endtask

    task automatic add_tone(input int start, input int len, input int amp);
        for (int k = 0; k < len; k++) begin
            stim_i[start+k] = pat_i[k % 16] ? amp : -amp;
            stim_q[start+k] = pat_q[k % 16] ? amp : -amp;
        end
    endtask

    task automatic scenario(input int thr, input int n, input bit do_rst);
        thresh = thr[3:0];
        tl_idx.delete();
        run_model(thr, n);
        if (do_rst) reset_dut();
        for (int k = 0; k < n; k++) send(k);
        drain();
        check("detect_count", detect_count, exp_det);
        check("tlast_count", tl_idx.size(), exp_det);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_i = 16'($urandom);
        pat_q = 16'($urandom);
        repeat (3) @(posedge clk);
        reset_dut();
        check_reset_outputs();

        // Silence: no detection, zero data, four-cycle latency
        clear_stim();
        scenario(12, 1000, 1'b1);
        check("s1_detects", tl_idx.size(), 0);
        check("s1_latency", (t_first_out - t_first_drive) / 10, 4);

        // Single burst
        clear_stim();
        add_tone(0, 160, 8192);
        scenario(12, 500, 1'b1);
        check("s2_detects", tl_idx.size(), 1);
        s2_idx = (tl_idx.size() > 0) ? tl_idx[0] : -1;
        check("s2_tlast_index", s2_idx, 79);

        // Second burst inside holdoff
        clear_stim();
        add_tone(0, 160, 8192);
        add_tone(200, 160, 8192);
        scenario(12, 700, 1'b1);
        check("s3a_detects", tl_idx.size(), 1);

        // Second burst after holdoff
        clear_stim();
        add_tone(0, 160, 8192);
        add_tone(500, 160, 8192);
        scenario(12, 1000, 1'b1);
        check("s3b_detects", tl_idx.size(), 2);
        if (tl_idx.size() == 2) begin
            check("s3b_idx0", tl_idx[0], 79);
            check("s3b_idx1", tl_idx[1], 579);
        end

        // Strong opposing sample at 60 breaks the run
        clear_stim();
        add_tone(0, 240, 8192);
        stim_i[60] = pat_i[60 % 16] ? -int'($urandom_range(28000, 32000)) : int'($urandom_range(28000, 32000));
        stim_q[60] = pat_q[60 % 16] ? -int'($urandom_range(28000, 32000)) : int'($urandom_range(28000, 32000));
        scenario(12, 500, 1'b1);
        check("s4_detects", tl_idx.size(), 1);
        if (tl_idx.size() > 0) check("s4_later", (tl_idx[0] > 79), 1);

        // Single burst under random backpressure and input gaps
        vld_pct = 70;
        rdy_pct = 50;
        clear_stim();
        add_tone(0, 160, 8192);
        scenario(12, 500, 1'b1);
        check("s5_detects", tl_idx.size(), 1);
        if (tl_idx.size() > 0) check("s5_same_index", tl_idx[0], s2_idx);
        vld_pct = 100;
        rdy_pct = 100;

        // Reset in mid-burst, then a clean burst
        clear_stim();
        add_tone(0, 160, 8192);
        thresh = 4'd12;
        tl_idx.delete();
        run_model(12, 70);
        reset_dut();
        for (int k = 0; k < 70; k++) send(k);
        reset_dut();
        check_reset_outputs();
        repeat (8) @(negedge clk);
        check("s6_no_tlast", tl_idx.size(), 0);
        check("s6_idle_valid", o_tvalid, 0);
        clear_stim();
        add_tone(40, 160, 8192);
        scenario(12, 500, 1'b0);
        check("s6_detects", tl_idx.size(), 1);
        if (tl_idx.size() > 0) check("s6_tlast_index", tl_idx[0], 119);

        // Randomised amplitude, noise and threshold
        for (int r = 0; r < 3; r++) begin
            int amp, nz, thr;
            amp = $urandom_range(3000, 12000);
            nz  = amp / 4;
            thr = $urandom_range(0, 15);
            vld_pct = 90;
            rdy_pct = 80;
            clear_stim();
            add_tone(20, 300, amp);
            for (int k = 0; k < 400; k++) begin
                stim_i[k] = stim_i[k] + int'($urandom_range(0, 2 * nz)) - nz;
                stim_q[k] = stim_q[k] + int'($urandom_range(0, 2 * nz)) - nz;
            end
            scenario(thr, 400, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
